// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller: register indices,
// decode flags and memory handshake in, stall/flush/forward/status out.
interface hazard_controller_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       Rs1E;
   logic [4:0]       Rs2E;
   logic [4:0]       RdE;
   logic [4:0]       RdM;
   logic [4:0]       RdW;
   logic             MEM_REG_E;
   logic             DE_WE_M;
   logic             DE_WE_W;
   logic             BRN_TAKEN_E;
   logic             MEM_REQ_M;
   logic             MEM_READY_M;
   logic             CNT_CLR;
   logic             STALL_F;
   logic             STALL_D;
   logic             STALL_E;
   logic             STALL_M;
   logic             FLUSH_D;
   logic             FLUSH_E;
   logic             FLUSH_W;
   logic [1:0]       FWD_A_E;
   logic [1:0]       FWD_B_E;
   logic             MEM_ERR;
   logic [CNT_W-1:0] STALL_CYCLES;
   logic [CNT_W-1:0] FLUSH_COUNT;

   // Controller side
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  MEM_REG_E, DE_WE_M, DE_WE_W, BRN_TAKEN_E,
      input  MEM_REQ_M, MEM_READY_M, CNT_CLR,
      output STALL_F, STALL_D, STALL_E, STALL_M,
      output FLUSH_D, FLUSH_E, FLUSH_W,
      output FWD_A_E, FWD_B_E, MEM_ERR, STALL_CYCLES, FLUSH_COUNT
   );

   // Pipeline side
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output MEM_REG_E, DE_WE_M, DE_WE_W, BRN_TAKEN_E,
      output MEM_REQ_M, MEM_READY_M, CNT_CLR,
      input  STALL_F, STALL_D, STALL_E, STALL_M,
      input  FLUSH_D, FLUSH_E, FLUSH_W,
      input  FWD_A_E, FWD_B_E, MEM_ERR, STALL_CYCLES, FLUSH_COUNT
   );
endinterface

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage core: stall/flush
// priority, execute-stage forwarding, memory-wait FSM with timeout
// watchdog and saturating stall/flush performance counters.
module hazard_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic               clk,
   input logic               reset,
   hazard_controller_if.slave hz
);
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERROR    = 2'd2;

   localparam int              WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   // Memory stage wins over writeback; x0 is hard-wired zero, never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic [4:0] rd_w,
                                          input logic       we_m,
                                          input logic       we_w);
      logic [1:0] sel;
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   logic [1:0]        state_r;
   logic [1:0]        state_n_s;
   logic [WAIT_W-1:0] wait_r;
   logic [WAIT_W-1:0] wait_n_s;
   logic              mem_err_r;
   logic              mem_err_n_s;
   logic [CNT_W-1:0]  stall_cycles_r;
   logic [CNT_W-1:0]  flush_count_r;

   logic       memstall_s;
   logic       load_use_s;
   logic [3:0] stall_s;   // {F, D, E, M}
   logic [2:0] flush_s;   // {D, E, W}

   assign memstall_s = hz.MEM_REQ_M & ~hz.MEM_READY_M;
   assign load_use_s = hz.MEM_REG_E & (hz.RdE != 5'd0) &
                       ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));

   // Next-state logic of the memory-wait FSM and its watchdog counter.
   always_comb begin
      state_n_s   = state_r;
      wait_n_s    = wait_r;
      mem_err_n_s = mem_err_r;
      case (state_r)
         ST_RUN: begin
            if (memstall_s) begin
               state_n_s = ST_MEM_WAIT;
               wait_n_s  = WAIT_W'(1);
            end else begin
               wait_n_s  = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (hz.MEM_READY_M || !hz.MEM_REQ_M) begin
               state_n_s = ST_RUN;
               wait_n_s  = '0;
            end else if (wait_r == WAIT_LAST) begin
               state_n_s   = ST_ERROR;
               mem_err_n_s = 1'b1;
            end else begin
               wait_n_s = wait_r + WAIT_W'(1);
            end
         end
         ST_ERROR: begin
            state_n_s   = ST_ERROR;
            mem_err_n_s = 1'b1;
         end
         default: begin
            // An unreachable encoding is treated as a fault, not silently recovered.
            state_n_s   = ST_ERROR;
            mem_err_n_s = 1'b1;
         end
      endcase
   end

   // FSM, watchdog counter and sticky error register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_RUN;
         wait_r    <= '0;
         mem_err_r <= 1'b0;
      end else begin
         state_r   <= state_n_s;
         wait_r    <= wait_n_s;
         mem_err_r <= mem_err_n_s;
      end
   end

   // Stall/flush priority: error, memory stall, taken branch, load-use.
   always_comb begin
      stall_s = 4'b0000;
      flush_s = 3'b000;
      if (state_r == ST_ERROR) begin
         stall_s = 4'b1111;
         flush_s = 3'b000;
      end else if (memstall_s) begin
         stall_s = 4'b1111;
         flush_s = 3'b001;
      end else if (hz.BRN_TAKEN_E) begin
         stall_s = 4'b0000;
         flush_s = 3'b110;
      end else if (load_use_s) begin
         stall_s = 4'b1100;
         flush_s = 3'b010;
      end else begin
         stall_s = 4'b0000;
         flush_s = 3'b000;
      end
   end

   // Saturating performance counters; clear beats increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_r <= '0;
         flush_count_r  <= '0;
      end else if (hz.CNT_CLR) begin
         stall_cycles_r <= '0;
         flush_count_r  <= '0;
      end else begin
         if (stall_s[3] && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
         end else begin
            stall_cycles_r <= stall_cycles_r;
         end
         if (flush_s[2] && (flush_count_r != CNT_MAX)) begin
            flush_count_r <= flush_count_r + CNT_W'(1);
         end else begin
            flush_count_r <= flush_count_r;
         end
      end
   end

   assign hz.STALL_F      = stall_s[3];
   assign hz.STALL_D      = stall_s[2];
   assign hz.STALL_E      = stall_s[1];
   assign hz.STALL_M      = stall_s[0];
   assign hz.FLUSH_D      = flush_s[2];
   assign hz.FLUSH_E      = flush_s[1];
   assign hz.FLUSH_W      = flush_s[0];
   assign hz.FWD_A_E      = fwd_sel(hz.Rs1E, hz.RdM, hz.RdW, hz.DE_WE_M, hz.DE_WE_W);
   assign hz.FWD_B_E      = fwd_sel(hz.Rs2E, hz.RdM, hz.RdW, hz.DE_WE_M, hz.DE_WE_W);
   assign hz.MEM_ERR      = mem_err_r;
   assign hz.STALL_CYCLES = stall_cycles_r;
   assign hz.FLUSH_COUNT  = flush_count_r;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT=4, CNT_W=4): a vector
// table for the combinational priority/forwarding paths, plus hand-written
// sequences for counters, memory wait, timeout, async reset and saturation.
module tb_hazard_controller;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   hazard_controller_if #(.CNT_W(4)) hz ();

   hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       mem_reg_e, we_m, we_w, brn, req, ready;
      logic [3:0] exp_stall;  // {F, D, E, M}
      logic [2:0] exp_flush;  // {D, E, W}
      logic [1:0] exp_fa, exp_fb;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] stalls();
      return {hz.STALL_F, hz.STALL_D, hz.STALL_E, hz.STALL_M};
   endfunction

   function automatic logic [2:0] flushes();
      return {hz.FLUSH_D, hz.FLUSH_E, hz.FLUSH_W};
   endfunction

   task automatic idle_inputs();
      hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
      hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
      hz.MEM_REG_E = 1'b0; hz.DE_WE_M = 1'b0; hz.DE_WE_W = 1'b0;
      hz.BRN_TAKEN_E = 1'b0; hz.MEM_REQ_M = 1'b0; hz.MEM_READY_M = 1'b0;
      hz.CNT_CLR = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
      hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
      hz.MEM_REG_E = v.mem_reg_e; hz.DE_WE_M = v.we_m; hz.DE_WE_W = v.we_w;
      hz.BRN_TAKEN_E = v.brn; hz.MEM_REQ_M = v.req; hz.MEM_READY_M = v.ready;
      hz.CNT_CLR = 1'b0;
   endtask

   task automatic load_use_inputs();
      idle_inputs();
      hz.MEM_REG_E = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
   endtask

   // One idle cycle with CNT_CLR so the counters read 0 at the next negedge.
   task automatic clear_counters();
      @(negedge clk);
      idle_inputs();
      hz.CNT_CLR = 1'b1;
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; errors = 0; checks = 0;
      idle_inputs();

      //              rs1d  rs2d  rs1e  rs2e  rde    rdm   rdw  ld   weM  weW  brn  req  rdy  stall    flush   fa     fb
      vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0,  5'd5, 5'd5, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b10, 2'b00};
      vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0,  5'd5, 5'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b01, 2'b00};
      vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0,  5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
      vecs[3]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0,  5'd9, 5'd9, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b00, 2'b10};
      vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0,  5'd4, 5'd9, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b00, 2'b01};
      vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7,  5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1100, 3'b010, 2'b00, 2'b00};
      vecs[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0,  5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
      vecs[7]  = '{5'd12,5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b1100, 3'b010, 2'b00, 2'b00};
      vecs[8]  = '{5'd12,5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 4'b0000, 3'b110, 2'b00, 2'b00};
      vecs[9]  = '{5'd12,5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 4'b1111, 3'b001, 2'b00, 2'b00};
      vecs[10] = '{5'd12,5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b1, 4'b0000, 3'b110, 2'b00, 2'b00};
      vecs[11] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7,  5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
      vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0,  5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};

      // Reset state
      #2;
      chk("rst_mem_err", 32'(hz.MEM_ERR), 32'd0);
      chk("rst_stall_cycles", 32'(hz.STALL_CYCLES), 32'd0);
      chk("rst_flush_count", 32'(hz.FLUSH_COUNT), 32'd0);
      chk("rst_stalls", 32'(stalls()), 32'd0);
      chk("rst_flushes", 32'(flushes()), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Combinational vector table
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         drive_vec(vecs[i]);
         #1;
         chk($sformatf("vec%0d_stall", i), 32'(stalls()), 32'(vecs[i].exp_stall));
         chk($sformatf("vec%0d_flush", i), 32'(flushes()), 32'(vecs[i].exp_flush));
         chk($sformatf("vec%0d_fwd_a", i), 32'(hz.FWD_A_E), 32'(vecs[i].exp_fa));
         chk($sformatf("vec%0d_fwd_b", i), 32'(hz.FWD_B_E), 32'(vecs[i].exp_fb));
      end

      // Single load-use bubble counts one stall cycle
      clear_counters();
      @(negedge clk);
      chk("lu_clr", 32'(hz.STALL_CYCLES), 32'd0);
      load_use_inputs();
      #1;
      chk("lu_stall", 32'(stalls()), 32'b1100);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("lu_after_stall", 32'(stalls()), 32'd0);
      chk("lu_stall_cycles", 32'(hz.STALL_CYCLES), 32'd1);

      // Branch beats load-use
      clear_counters();
      @(negedge clk);
      load_use_inputs();
      hz.BRN_TAKEN_E = 1'b1;
      #1;
      chk("brlu_stall_f", 32'(hz.STALL_F), 32'd0);
      chk("brlu_flush", 32'(flushes()), 32'b110);
      @(negedge clk);
      idle_inputs();
      chk("brlu_flush_count", 32'(hz.FLUSH_COUNT), 32'd1);
      chk("brlu_stall_cycles", 32'(hz.STALL_CYCLES), 32'd0);

      // Memory wait ending on the last allowed cycle, then a back-to-back wait
      clear_counters();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle_inputs();
         hz.MEM_REQ_M = 1'b1; hz.BRN_TAKEN_E = 1'b1;
         #1;
         chk($sformatf("mw_stall_c%0d", c), 32'(stalls()), 32'b1111);
         chk($sformatf("mw_flush_c%0d", c), 32'(flushes()), 32'b001);
      end
      @(negedge clk);
      hz.MEM_READY_M = 1'b1;
      #1;
      chk("mw_ready_stall", 32'(stalls()), 32'd0);
      chk("mw_ready_flush", 32'(flushes()), 32'b110);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         idle_inputs();
         hz.MEM_REQ_M = 1'b1;
         #1;
         chk($sformatf("mw2_stall_c%0d", c), 32'(stalls()), 32'b1111);
      end
      @(negedge clk);
      hz.MEM_READY_M = 1'b1;
      #1;
      chk("mw2_ready_stall", 32'(stalls()), 32'd0);
      @(negedge clk);
      idle_inputs();
      chk("mw_mem_err", 32'(hz.MEM_ERR), 32'd0);
      chk("mw_stall_cycles", 32'(hz.STALL_CYCLES), 32'd6);
      chk("mw_flush_count", 32'(hz.FLUSH_COUNT), 32'd1);

      // Timeout into ERROR, then async reset mid-cycle
      clear_counters();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("to_err_c%0d", c), 32'(hz.MEM_ERR), 32'd0);
         idle_inputs();
         hz.MEM_REQ_M = 1'b1;
         #1;
         chk($sformatf("to_stall_c%0d", c), 32'(stalls()), 32'b1111);
         chk($sformatf("to_flush_c%0d", c), 32'(flushes()), 32'b001);
      end
      @(negedge clk);
      chk("to_err_c4", 32'(hz.MEM_ERR), 32'd1);
      #1;
      chk("to_stall_c4", 32'(stalls()), 32'b1111);
      chk("to_flush_c4", 32'(flushes()), 32'b000);
      @(negedge clk);
      hz.MEM_READY_M = 1'b1; hz.BRN_TAKEN_E = 1'b1;
      #1;
      chk("to_ready_stall", 32'(stalls()), 32'b1111);
      chk("to_ready_flush", 32'(flushes()), 32'b000);
      @(negedge clk);
      chk("to_err_sticky", 32'(hz.MEM_ERR), 32'd1);
      chk("to_stall_cycles", 32'(hz.STALL_CYCLES), 32'd6);
      #1;
      reset = 1'b1;
      #1;
      chk("to_rst_err", 32'(hz.MEM_ERR), 32'd0);
      chk("to_rst_cnt", 32'(hz.STALL_CYCLES), 32'd0);
      chk("to_rst_stall", 32'(stalls()), 32'd0);
      chk("to_rst_flush", 32'(flushes()), 32'b110);
      #1;
      reset = 1'b0;
      @(negedge clk);
      idle_inputs();
      chk("to_post_rst_err", 32'(hz.MEM_ERR), 32'd0);

      // Saturation at 15 and clear during a stall
      clear_counters();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 14) chk("sat_k14", 32'(hz.STALL_CYCLES), 32'd14);
         if (k == 15) chk("sat_k15", 32'(hz.STALL_CYCLES), 32'd15);
         load_use_inputs();
      end
      @(negedge clk);
      chk("sat_hold", 32'(hz.STALL_CYCLES), 32'd15);
      load_use_inputs();
      hz.CNT_CLR = 1'b1;
      @(negedge clk);
      chk("sat_clr", 32'(hz.STALL_CYCLES), 32'd0);
      load_use_inputs();
      @(negedge clk);
      chk("sat_after_clr", 32'(hz.STALL_CYCLES), 32'd1);
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
